// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Memory-mapped scan controller for an eight-digit, common-anode
// seven-segment display. The CPU writes into shadow registers. The shadows
// are copied into the active registers at a frame boundary (the tick that
// ends digit slot 7), or at once on a force request, so a frame never shows
// a mix of old and new data. Each digit slot starts with a blanking gap in
// which every anode is off, to suppress ghosting.
//
// Parameters
//   DIV_W   scan divider width; one digit slot lasts 2^DIV_W cycles
//   BLANK   blank cycles at the start of each slot (1 <= BLANK < 2^DIV_W)
//
// Ports
//   clk_i     system clock, rising edge
//   reset_i   asynchronous, active-high reset
//   we_i      write strobe from the IO decoder
//   addr_i    register select: 0 DATA, 1 DPMASK, 2 ENMASK, 3 CTRL/STATUS
//   wdata_i   write data; CTRL bit 0 = force commit
//   rdata_o   combinational readback (shadows, or {pending, 0, idx})
//   an_o      anode enables, active low, registered
//   a2g_o     segments a..g on bits 6..0, active low, registered
//   dp_o      decimal point, active low, registered
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int DIV_W = 17,
    parameter int BLANK = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [7:0]  an_o,
    output logic [6:0]  a2g_o,
    output logic        dp_o
);

    localparam logic [DIV_W-1:0] BLANK_CNT = DIV_W'(BLANK);

    // Scan state
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;

    // CPU-visible shadow registers
    logic [31:0] sh_data_q, sh_data_d;
    logic [7:0]  sh_dp_q, sh_dp_d;
    logic [7:0]  sh_en_q, sh_en_d;
    logic        pending_q, pending_d;

    // Active registers that drive the display
    logic [31:0] act_data_q, act_data_d;
    logic [7:0]  act_dp_q, act_dp_d;
    logic [7:0]  act_en_q, act_en_d;

    // Registered display outputs
    logic [7:0] an_q, an_d;
    logic [6:0] a2g_q, a2g_d;
    logic       dp_q, dp_d;

    logic tick;
    logic shadow_wr;
    logic force_commit;
    logic wrap_commit;
    logic commit;
    logic lit;

    // Segment pattern (a..g, active low) for one hex nibble
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Split the active data word into one nibble per digit
    logic [3:0] act_nib [8];
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nib
            assign act_nib[gi] = act_data_q[4*gi +: 4];
        end
    endgenerate

    assign tick         = &cnt_q;
    assign shadow_wr    = we_i && (addr_i != 2'd3);
    assign force_commit = we_i && (addr_i == 2'd3) && wdata_i[0];
    assign wrap_commit  = tick && (idx_q == 3'd7) && pending_q;
    assign commit       = wrap_commit || force_commit;

    // Digit is lit only past the blanking gap and when enabled
    assign lit = (cnt_q >= BLANK_CNT) && act_en_q[idx_q];

    always_comb begin
        cnt_d      = cnt_q + DIV_W'(1);
        idx_d      = tick ? idx_q + 3'd1 : idx_q;

        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        sh_en_d    = sh_en_q;
        pending_d  = pending_q;
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;

        // Commit copies the pre-write shadow values
        if (commit) begin
            act_data_d = sh_data_q;
            act_dp_d   = sh_dp_q;
            act_en_d   = sh_en_q;
            pending_d  = 1'b0;
        end

        // A shadow write overrides the pending clear of a same-cycle commit
        if (shadow_wr) begin
            case (addr_i)
                2'd0:    sh_data_d = wdata_i;
                2'd1:    sh_dp_d   = wdata_i[7:0];
                default: sh_en_d   = wdata_i[7:0];
            endcase
            pending_d = 1'b1;
        end

        if (lit) begin
            an_d  = ~(8'd1 << idx_q);
            a2g_d = hex_seg(act_nib[idx_q]);
            dp_d  = ~act_dp_q[idx_q];
        end else begin
            an_d  = 8'hFF;
            a2g_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            sh_data_q  <= 32'h0;
            sh_dp_q    <= 8'h00;
            sh_en_q    <= 8'hFF;
            pending_q  <= 1'b0;
            act_data_q <= 32'h0;
            act_dp_q   <= 8'h00;
            act_en_q   <= 8'hFF;
            an_q       <= 8'hFF;
            a2g_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            sh_en_q    <= sh_en_d;
            pending_q  <= pending_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            act_en_q   <= act_en_d;
            an_q       <= an_d;
            a2g_q      <= a2g_d;
            dp_q       <= dp_d;
        end
    end

    always_comb begin
        case (addr_i)
            2'd0:    rdata_o = sh_data_q;
            2'd1:    rdata_o = {24'h0, sh_dp_q};
            2'd2:    rdata_o = {24'h0, sh_en_q};
            default: rdata_o = {pending_q, 28'h0, idx_q};
        endcase
    end

    assign an_o  = an_q;
    assign a2g_o = a2g_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Bench for seg7_scan_ctrl with DIV_W=4 (16-cycle slots) and BLANK=2.
// A behavioural model of the register file and scan counter runs alongside
// the DUT. On every rising edge it pushes the expected display word for the
// following cycle into a queue; on every falling edge that word is popped and
// compared with the registered outputs. Directed checks with fixed expected
// values cover reset, deferred commit, masks, write/commit collision and an
// asynchronous mid-slot reset.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int DIV_W = 4;
    localparam int BLANK = 2;
    localparam logic [15:0] RESET_DISP = {8'hFF, 7'h7F, 1'b1};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  an;
    logic [6:0]  a2g;
    logic        dp;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_ctrl #(
        .DIV_W (DIV_W),
        .BLANK (BLANK)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .an_o    (an),
        .a2g_o   (a2g),
        .dp_o    (dp)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h, expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0]  m_cnt;
    logic [2:0]  m_idx;
    logic [31:0] m_sh_data, m_act_data;
    logic [7:0]  m_sh_dp, m_sh_en, m_act_dp, m_act_en;
    logic        m_pend;
    logic        m_commit;
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;

    function automatic logic [15:0] exp_disp(input logic [3:0] c, input logic [2:0] i,
                                             input logic [31:0] d, input logic [7:0] dpm,
                                             input logic [7:0] en);
        logic [3:0] nib;
        if (c < 4'(BLANK) || !en[i]) return RESET_DISP;
        nib = d[4*i +: 4];
        return {~(8'h01 << i), seg_tab[nib], ~dpm[i]};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_sh_data;
            2'd1:    return {24'h0, m_sh_dp};
            2'd2:    return {24'h0, m_sh_en};
            default: return {m_pend, 28'h0, m_idx};
        endcase
    endfunction

    assign m_commit = (m_cnt == 4'hF && m_idx == 3'd7 && m_pend) ||
                      (we && addr == 2'd3 && wdata[0]);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt      <= 4'd0;
            m_idx      <= 3'd0;
            m_sh_data  <= 32'h0;
            m_sh_dp    <= 8'h00;
            m_sh_en    <= 8'hFF;
            m_pend     <= 1'b0;
            m_act_data <= 32'h0;
            m_act_dp   <= 8'h00;
            m_act_en   <= 8'hFF;
            exp_q.delete();
        end else begin
            exp_q.push_back(exp_disp(m_cnt, m_idx, m_act_data, m_act_dp, m_act_en));
            m_cnt <= m_cnt + 4'd1;
            if (m_cnt == 4'hF) m_idx <= m_idx + 3'd1;
            if (m_commit) begin
                m_act_data <= m_sh_data;
                m_act_dp   <= m_sh_dp;
                m_act_en   <= m_sh_en;
            end
            if (we && addr != 2'd3) begin
                case (addr)
                    2'd0:    m_sh_data <= wdata;
                    2'd1:    m_sh_dp   <= wdata[7:0];
                    default: m_sh_en   <= wdata[7:0];
                endcase
                m_pend <= 1'b1;
            end else if (m_commit) begin
                m_pend <= 1'b0;
            end
        end
    end

    // Scoreboard: compare display outputs every falling edge
    always @(negedge clk) begin
        if (reset || exp_q.size() == 0) mon_exp = RESET_DISP;
        else                            mon_exp = exp_q.pop_front();
        check_eq("disp", {16'h0, an, a2g, dp}, {16'h0, mon_exp});
        check_eq("one_anode", 32'($countones(~an) <= 1), 32'd1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        $display("[TB] WR addr=%0d data=%08h idx=%0d cnt=%0d", a, d, m_idx, m_cnt);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag);
        addr = a;
        #1;
        $display("[TB] RD addr=%0d data=%08h", a, rdata);
        check_eq(tag, rdata, exp_rd(a));
    endtask

    // Stop on the falling edge where the model holds (i, c); the registered
    // outputs then show the state one cycle earlier.
    task automatic wait_at(input logic [2:0] i, input logic [3:0] c);
        int n = 0;
        @(negedge clk);
        while (!(m_idx == i && m_cnt == c) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_eq("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_disp(input string tag, input logic [7:0] e_an,
                            input logic [6:0] e_seg, input logic e_dp);
        check_eq(tag, {16'h0, an, a2g, dp}, {16'h0, e_an, e_seg, e_dp});
    endtask

    initial begin
        // 1. reset state
        #1 reset = 1'b1;
        #1 chk_disp("rst_async", 8'hFF, 7'h7F, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_disp("blank_d0", 8'hFF, 7'h7F, 1'b1);
        wait_at(3'd0, 4'd7);
        chk_disp("lit_d0_zero", 8'hFE, 7'b0000001, 1'b1);

        // 2. deferred commit
        wait_at(3'd3, 4'd4);
        wr(2'd0, 32'h12345678);
        rd(2'd3, "status_pend");
        check_eq("pend_set", 32'(rdata[31]), 32'd1);
        rd(2'd0, "data_rb");
        check_eq("data_shadow", rdata, 32'h12345678);
        wait_at(3'd7, 4'd6);
        chk_disp("d7_before_wrap", 8'h7F, 7'b0000001, 1'b1);
        wait_at(3'd0, 4'd3);
        chk_disp("d0_after_wrap", 8'hFE, 7'b0000000, 1'b1);
        rd(2'd3, "status_after");
        check_eq("pend_clear", 32'(rdata[31]), 32'd0);

        // 3. masks and force commit
        @(negedge clk);
        wr(2'd2, 32'h0000000F);
        wr(2'd1, 32'h00000001);
        wr(2'd3, 32'h00000001);
        rd(2'd3, "status_force");
        check_eq("pend_force", 32'(rdata[31]), 32'd0);
        rd(2'd2, "en_rb");
        wait_at(3'd5, 4'd8);
        chk_disp("d5_masked", 8'hFF, 7'h7F, 1'b1);
        wait_at(3'd0, 4'd8);
        chk_disp("d0_dp_on", 8'hFE, 7'b0000000, 1'b0);
        wait_at(3'd1, 4'd8);
        chk_disp("d1_dp_off", 8'hFD, 7'b0001111, 1'b1);

        // 4. write/commit collision
        wr(2'd0, 32'h11111111);
        wait_at(3'd7, 4'd15);
        wr(2'd0, 32'hAAAAAAAA);
        rd(2'd3, "status_coll");
        check_eq("pend_kept", 32'(rdata[31]), 32'd1);
        rd(2'd0, "data_coll");
        check_eq("data_coll_new", rdata, 32'hAAAAAAAA);
        wait_at(3'd0, 4'd8);
        chk_disp("coll_d0_one", 8'hFE, 7'b1001111, 1'b0);
        wait_at(3'd3, 4'd8);
        chk_disp("coll_d3_one", 8'hF7, 7'b1001111, 1'b1);
        wait_at(3'd0, 4'd8);
        chk_disp("coll_d0_A", 8'hFE, 7'b0001000, 1'b0);
        rd(2'd3, "status_A");
        check_eq("pend_A", 32'(rdata[31]), 32'd0);

        // 5. asynchronous reset while digit 5 is lit
        @(negedge clk);
        wr(2'd2, 32'h000000FF);
        wr(2'd3, 32'h00000001);
        wait_at(3'd5, 4'd8);
        chk_disp("d5_lit", 8'hDF, 7'b0001000, 1'b1);
        #2 reset = 1'b1;
        #1 chk_disp("rst_mid", 8'hFF, 7'h7F, 1'b1);
        rd(2'd0, "rst_rb0");
        check_eq("rst_data", rdata, 32'h0);
        rd(2'd1, "rst_rb1");
        check_eq("rst_dp", rdata, 32'h0);
        rd(2'd2, "rst_rb2");
        check_eq("rst_en", rdata, 32'h000000FF);
        rd(2'd3, "rst_rb3");
        check_eq("rst_status", rdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (7) @(negedge clk);
        chk_disp("resume_d0", 8'hFE, 7'b0000001, 1'b1);
        rd(2'd3, "resume_status");
        check_eq("resume_idx", rdata, 32'h0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
